// File: rtl/tlb_pkg.sv
// Shared types for the multi-port joint TLB: entry layout, field widths and
// the invalidation walker state encoding.
package tlb_pkg;

    localparam int VPN2_W     = 19;
    localparam int PFN_W      = 20;
    localparam int C_W        = 3;
    // Entries store ASIDs zero-extended to this width so the struct is fixed.
    localparam int ASID_MAX_W = 16;

    typedef struct packed {
        logic [VPN2_W-1:0]     vpn2;
        logic [ASID_MAX_W-1:0] asid;
        logic                  g;
        logic [PFN_W-1:0]      pfn0;
        logic [C_W-1:0]        c0;
        logic                  d0;
        logic                  v0;
        logic [PFN_W-1:0]      pfn1;
        logic [C_W-1:0]        c1;
        logic                  d1;
        logic                  v1;
        logic                  e;
    } tlb_entry_t;

    typedef enum logic {
        INV_IDLE = 1'b0,
        INV_WALK = 1'b1
    } inv_state_t;

endpackage

// File: rtl/tlb_match_port.sv
// One registered TLB search port: match vector, lowest-index priority pick,
// field mux and (with TLB_MULTIHIT_EN) a registered multi-hit flag.
module tlb_match_port
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 32,
    parameter int ASIDW  = 8,
    localparam int IW    = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  tlb_entry_t        entries [TLBNUM],
    input  logic              valid,
    input  logic [VPN2_W-1:0] vpn2,
    input  logic              odd_page,
    input  logic [ASIDW-1:0]  asid,
    output logic              rvalid,
    output logic              found,
    output logic [IW-1:0]     index,
    output logic [PFN_W-1:0]  pfn,
    output logic [C_W-1:0]    c,
    output logic              d,
    output logic              v,
    output logic              multihit
);

    logic [TLBNUM-1:0]     match;
    logic [ASID_MAX_W-1:0] key_asid;
    logic                  hit;
    logic [IW-1:0]         sel;

    assign key_asid = ASID_MAX_W'(asid);

    always_comb begin
        match = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            match[i] = entries[i].e && (entries[i].vpn2 == vpn2) &&
                       ((entries[i].asid == key_asid) || entries[i].g);
        end
    end

    // Scan downwards so the lowest matching index is the one left in sel.
    always_comb begin
        hit = |match;
        sel = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match[i]) sel = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            found  <= 1'b0;
            index  <= '0;
            pfn    <= '0;
            c      <= '0;
            d      <= 1'b0;
            v      <= 1'b0;
        end else begin
            rvalid <= valid;
            if (valid) begin
                found <= hit;
                index <= hit ? sel : '0;
                if (!hit) begin
                    pfn <= '0;
                    c   <= '0;
                    d   <= 1'b0;
                    v   <= 1'b0;
                end else if (odd_page) begin
                    pfn <= entries[sel].pfn1;
                    c   <= entries[sel].c1;
                    d   <= entries[sel].d1;
                    v   <= entries[sel].v1;
                end else begin
                    pfn <= entries[sel].pfn0;
                    c   <= entries[sel].c0;
                    d   <= entries[sel].d0;
                    v   <= entries[sel].v0;
                end
            end
        end
    end

`ifdef TLB_MULTIHIT_EN
    logic multi;

    // Clearing the lowest set bit leaves something only if two or more matched.
    assign multi = |(match & (match - TLBNUM'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            multihit <= 1'b0;
        end else if (valid) begin
            multihit <= multi;
        end
    end
`else
    assign multihit = 1'b0;
`endif

endmodule

// File: rtl/tlb_mp.sv
// Multi-port MIPS-style joint TLB: NPORT search ports, TLBR read port, TLBWI/TLBWR
// write port, Random register and ASID invalidation walker. Option: TLB_MULTIHIT_EN.
module tlb_mp
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 32,
    parameter int NPORT  = 2,
    parameter int ASIDW  = 8,
    localparam int IW    = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORT-1:0]        s_valid,
    input  logic [NPORT*VPN2_W-1:0] s_vpn2,
    input  logic [NPORT-1:0]        s_odd_page,
    input  logic [NPORT*ASIDW-1:0]  s_asid,
    output logic [NPORT-1:0]        s_rvalid,
    output logic [NPORT-1:0]        s_found,
    output logic [NPORT*IW-1:0]     s_index,
    output logic [NPORT*PFN_W-1:0]  s_pfn,
    output logic [NPORT*C_W-1:0]    s_c,
    output logic [NPORT-1:0]        s_d,
    output logic [NPORT-1:0]        s_v,
    output logic [NPORT-1:0]        s_multihit,
    input  logic                    we,
    input  logic                    w_random,
    input  logic [IW-1:0]           w_index,
    input  logic [VPN2_W-1:0]       w_vpn2,
    input  logic [ASIDW-1:0]        w_asid,
    input  logic                    w_g,
    input  logic [PFN_W-1:0]        w_pfn0,
    input  logic [C_W-1:0]          w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [PFN_W-1:0]        w_pfn1,
    input  logic [C_W-1:0]          w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,
    input  logic                    r_req,
    input  logic [IW-1:0]           r_index,
    output logic                    r_rvalid,
    output logic [VPN2_W-1:0]       r_vpn2,
    output logic [ASIDW-1:0]        r_asid,
    output logic                    r_g,
    output logic [PFN_W-1:0]        r_pfn0,
    output logic [C_W-1:0]          r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [PFN_W-1:0]        r_pfn1,
    output logic [C_W-1:0]          r_c1,
    output logic                    r_d1,
    output logic                    r_v1,
    input  logic [IW:0]             wired,
    output logic [IW-1:0]           rnd_index,
    input  logic                    inv_req,
    input  logic                    inv_all,
    input  logic [ASIDW-1:0]        inv_asid,
    output logic                    inv_busy,
    output inv_state_t              inv_state
);

    localparam logic [IW-1:0] RND_MAX = IW'(TLBNUM - 1);
    localparam logic [IW:0]   NUM_W   = (IW + 1)'(TLBNUM);

    tlb_entry_t       entries [TLBNUM];
    tlb_entry_t       wr_entry;
    logic [IW-1:0]    wr_idx;
    inv_state_t       state_q, state_d;
    logic [IW-1:0]    walk_idx, walk_idx_d;
    logic             inv_all_q;
    logic [ASIDW-1:0] inv_asid_q;
    logic             walk_clear;

    assign wr_idx = w_random ? rnd_index : w_index;

    always_comb begin
        wr_entry      = '0;
        wr_entry.vpn2 = w_vpn2;
        wr_entry.asid = ASID_MAX_W'(w_asid);
        wr_entry.g    = w_g;
        wr_entry.pfn0 = w_pfn0;
        wr_entry.c0   = w_c0;
        wr_entry.d0   = w_d0;
        wr_entry.v0   = w_v0;
        wr_entry.pfn1 = w_pfn1;
        wr_entry.c1   = w_c1;
        wr_entry.d1   = w_d1;
        wr_entry.v1   = w_v1;
        wr_entry.e    = 1'b1;
    end

    assign walk_clear = (state_q == INV_WALK) &&
                        (inv_all_q || (!entries[walk_idx].g &&
                         (entries[walk_idx].asid == ASID_MAX_W'(inv_asid_q))));

    // Only E is reset; the write is applied after the walk clear so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) entries[i].e <= 1'b0;
        end else begin
            if (walk_clear) entries[walk_idx].e <= 1'b0;
            if (we) entries[wr_idx] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INV_IDLE;
            walk_idx   <= '0;
            inv_all_q  <= 1'b0;
            inv_asid_q <= '0;
        end else begin
            state_q  <= state_d;
            walk_idx <= walk_idx_d;
            if (state_q == INV_IDLE && inv_req) begin
                inv_all_q  <= inv_all;
                inv_asid_q <= inv_asid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        walk_idx_d = walk_idx;
        case (state_q)
            INV_IDLE: begin
                if (inv_req) begin
                    state_d    = INV_WALK;
                    walk_idx_d = '0;
                end
            end
            INV_WALK: begin
                if (walk_idx == RND_MAX) state_d = INV_IDLE;
                else walk_idx_d = walk_idx + IW'(1);
            end
            default: state_d = INV_IDLE;
        endcase
    end

    assign inv_busy  = (state_q == INV_WALK);
    assign inv_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_index <= RND_MAX;
        end else if (wired >= NUM_W || {1'b0, rnd_index} <= wired) begin
            rnd_index <= RND_MAX;
        end else begin
            rnd_index <= rnd_index - IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_vpn2   <= '0;
            r_asid   <= '0;
            r_g      <= 1'b0;
            r_pfn0   <= '0;
            r_c0     <= '0;
            r_d0     <= 1'b0;
            r_v0     <= 1'b0;
            r_pfn1   <= '0;
            r_c1     <= '0;
            r_d1     <= 1'b0;
            r_v1     <= 1'b0;
        end else begin
            r_rvalid <= r_req;
            if (r_req) begin
                r_vpn2 <= entries[r_index].vpn2;
                r_asid <= entries[r_index].asid[ASIDW-1:0];
                r_g    <= entries[r_index].g;
                r_pfn0 <= entries[r_index].pfn0;
                r_c0   <= entries[r_index].c0;
                r_d0   <= entries[r_index].d0;
                r_v0   <= entries[r_index].v0;
                r_pfn1 <= entries[r_index].pfn1;
                r_c1   <= entries[r_index].c1;
                r_d1   <= entries[r_index].d1;
                r_v1   <= entries[r_index].v1;
            end
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        tlb_match_port #(
            .TLBNUM (TLBNUM),
            .ASIDW  (ASIDW)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .entries  (entries),
            .valid    (s_valid[p]),
            .vpn2     (s_vpn2[p*VPN2_W +: VPN2_W]),
            .odd_page (s_odd_page[p]),
            .asid     (s_asid[p*ASIDW +: ASIDW]),
            .rvalid   (s_rvalid[p]),
            .found    (s_found[p]),
            .index    (s_index[p*IW +: IW]),
            .pfn      (s_pfn[p*PFN_W +: PFN_W]),
            .c        (s_c[p*C_W +: C_W]),
            .d        (s_d[p]),
            .v        (s_v[p]),
            .multihit (s_multihit[p])
        );
    end

endmodule

// File: doc/tlb_mp.md
# tlb_mp

Parametrised multi-port MIPS-style joint TLB, successor to the 16-entry two-port TLB. Serves NPORT registered lookup ports (fetch, load/store, TLBP), a registered read port for TLBR, an indexed/random write port for TLBWI/TLBWR, and a background ASID invalidation engine. It sits between the CP0 register file and the address-translation stages of the pipeline.

## Interface
- TLBNUM, 32, entry count (power of two, 8..64); IW = $clog2(TLBNUM)
- NPORT, 2, number of search ports (1..4)
- ASIDW, 8, ASID width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  NPORT  lookup request per port
- s_vpn2 / s_odd_page / s_asid  in  NPORT*19 / NPORT / NPORT*ASIDW  lookup key, port p in slice p
- s_rvalid  out  NPORT  result valid, one cycle after s_valid
- s_found / s_index / s_pfn / s_c / s_d / s_v  out  NPORT / NPORT*IW / NPORT*20 / NPORT*3 / NPORT / NPORT  registered result
- s_multihit  out  NPORT  more than one entry matched (see Configuration)
- we  in  1  write strobe; w_random  in  1  use rnd_index instead of w_index
- w_index  in  IW; w_vpn2 19; w_asid ASIDW; w_g 1; w_pfn0/w_pfn1 20; w_c0/w_c1 3; w_d0/w_d1/w_v0/w_v1 1  write data
- r_req  in  1; r_index  in  IW  read request
- r_rvalid  out  1; r_vpn2/r_asid/r_g/r_pfn0/r_c0/r_d0/r_v0/r_pfn1/r_c1/r_d1/r_v1  out  widths as write  registered read data
- wired  in  IW+1  CP0 Wired value
- rnd_index  out  IW  current Random value
- inv_req  in  1; inv_all  in  1; inv_asid  in  ASIDW  invalidate command
- inv_busy  out  1  invalidation walk in progress

## Operation
- Each entry holds an internal E (exists) bit; match = E && vpn2 equal && (asid equal || G).
- Lookup: combinational match on current array, priority-encoded to lowest matching index; all result fields registered. No match: found=0, index/pfn/c/d/v = 0.
- Read: registered copy of entry r_index when r_req; E=0 entries read as their stored fields (E not visible).
- Write: on we, entry at (w_random ? rnd_index : w_index) loaded, E set to 1.
- Random: reset to TLBNUM-1; decrements each cycle; when current value <= wired, next is TLBNUM-1. If wired >= TLBNUM, held at TLBNUM-1. Write with w_random uses the pre-edge value.
- Invalidation FSM: IDLE -> WALK on inv_req (accepted only in IDLE; ignored while busy). WALK counter i = 0..TLBNUM-1, one entry per cycle: clear E if inv_all, or (!G && asid == latched inv_asid). After i = TLBNUM-1, return to IDLE. inv_busy = (state == WALK).
- Simultaneous we and walk clear on same index: write wins (E=1).

## Timing
- Lookup and read latency 1 cycle; s_rvalid/r_rvalid are s_valid/r_req delayed one cycle; result fields hold last value when not valid.
- Write at edge N visible to lookups/reads presented in cycle N+1; same-cycle lookup sees old contents.
- Invalidation takes exactly TLBNUM cycles in WALK; lookups continue during walk and see entries cleared so far.
- Reset: all E cleared, state IDLE, rnd_index = TLBNUM-1, every output 0. Reset mid-walk aborts to IDLE. Entry fields other than E not reset.

## Configuration
- TLB_MULTIHIT_EN defined: s_multihit[p] registered, 1 when two or more entries match; index/fields still from lowest match.
- Undefined: no population-count logic; s_multihit tied 0.

## Structure
- tlb_pkg: entry struct (vpn2, asid, g, pfn0/1, c0/1, d0/1, v0/1, e), field width constants, FSM state enum.
- Sub-module tlb_match_port: one search port's match vector, priority encoder, field mux, optional multi-hit; generated NPORT times.

## Test plan
- Reset, lookup vpn2 0x00000 asid 0 on all ports -> found=0, s_rvalid=1 next cycle, all fields 0.
- Write index 5 (vpn2 0x12345, asid 3, g=0, pfn0 0xAAAAA, pfn1 0xBBBBB); lookup asid 3 odd=1 -> found=1, index 5, pfn 0xBBBBB; asid 4 -> found=0; rewrite with g=1 -> asid 4 hits.
- Same vpn2 written to entries 2 and 9 -> index 2; multihit=1 with TLB_MULTIHIT_EN, 0 without.
- wired=4: rnd_index sequence 31,30..4,31; w_random write lands at sampled value; wired=40 -> stays 31.
- inv_req asid 3 with entries asid 3 (g=0), asid 3 (g=1), asid 7 -> after 32 busy cycles only non-global asid 3 misses; inv_req during walk ignored.
- Reset asserted at walk cycle 10 -> inv_busy=0 next cycle, all lookups miss.
